// File: rtl/dmux_slow2fast_sync.sv
// Data-mux synchronizer: only the valid crosses through a flop chain; its rising edge
// selects the (stable) payload into a recirculating output register. Optional macro: DMUX_CLEAR_EN.
`timescale 1ns/1ps
module dmux_slow2fast_sync #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_in_valid,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  data_out_valid
);

  generate
    if ((SYNC_STAGES < 2) || (SYNC_STAGES > 4)) begin : g_bad_stages
      $error("dmux_slow2fast_sync: SYNC_STAGES must be in 2..4");
    end
  endgenerate

  logic [SYNC_STAGES-1:0] sync_r;
  logic                   hist_r;
  logic                   sel_s;
  logic [DATA_WIDTH-1:0]  data_nxt_s;
  logic [DATA_WIDTH-1:0]  data_out_r;
  logic                   data_out_valid_r;

  // Valid synchronizer chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_r <= {SYNC_STAGES{1'b0}};
      hist_r <= 1'b0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], data_in_valid};
      hist_r <= sync_r[SYNC_STAGES-1];
    end
  end

  // Rising edge of synchronized valid steers the capture mux
  always_comb begin
    sel_s      = sync_r[SYNC_STAGES-1] & ~hist_r;
    data_nxt_s = data_out_r;
    if (sel_s) begin
      data_nxt_s = data_in;
    end else begin
`ifdef DMUX_CLEAR_EN
      data_nxt_s = {DATA_WIDTH{1'b0}};
`else
      data_nxt_s = data_out_r;
`endif
    end
  end

  // Registered payload and one-cycle valid pulse
  always_ff @(posedge clk) begin
    if (rst) begin
      data_out_r       <= {DATA_WIDTH{1'b0}};
      data_out_valid_r <= 1'b0;
    end else begin
      data_out_r       <= data_nxt_s;
      data_out_valid_r <= sel_s;
    end
  end

  assign data_out       = data_out_r;
  assign data_out_valid = data_out_valid_r;

endmodule

// File: tb/tb_dmux_slow2fast_sync.sv
// Bench for dmux_slow2fast_sync: two instances (2 and 3 sync stages) share stimulus and
// are checked every cycle against an event-queue model, plus literal spot checks.
`timescale 1ns/1ps
module tb_dmux_slow2fast_sync;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] data_in;
  logic       data_in_valid;
  logic [7:0] data_out2, data_out3;
  logic       data_out_valid2, data_out_valid3;

  int total = 0;
  int bad   = 0;

  // model state: edge count, last sampled valid, pending capture edges per instance
  int         ecnt = 0;
  bit         prev_v = 1'b0;
  int         pend2[$];
  int         pend3[$];
  logic [7:0] exp_d2 = 8'd0, exp_d3 = 8'd0;
  logic       exp_v2 = 1'b0, exp_v3 = 1'b0;
  int         pulses2 = 0, pulses3 = 0;

  always #5 clk = ~clk;

  dmux_slow2fast_sync #(.DATA_WIDTH(8), .SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out2), .data_out_valid(data_out_valid2));

  dmux_slow2fast_sync #(.DATA_WIDTH(8), .SYNC_STAGES(3)) dut3 (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_valid(data_in_valid),
    .data_out(data_out3), .data_out_valid(data_out_valid3));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at edge %0d: got %0h want %0h", name, ecnt, act, exp);
    end
  endtask

  // One clock edge: advance the model with the inputs that edge sampled, then compare
  task automatic tick();
    @(posedge clk);
    #1;
    ecnt++;
    if (rst) begin
      prev_v = 1'b0;
      pend2.delete();
      pend3.delete();
      exp_d2 = 8'd0; exp_v2 = 1'b0;
      exp_d3 = 8'd0; exp_v3 = 1'b0;
    end else begin
      if (data_in_valid && !prev_v) begin
        pend2.push_back(ecnt + 2);
        pend3.push_back(ecnt + 3);
      end
      prev_v = data_in_valid;
      if ((pend2.size() > 0) && (pend2[0] == ecnt)) begin
        pend2.delete(0);
        exp_v2 = 1'b1; exp_d2 = data_in;
      end else begin
        exp_v2 = 1'b0;
`ifdef DMUX_CLEAR_EN
        exp_d2 = 8'd0;
`endif
      end
      if ((pend3.size() > 0) && (pend3[0] == ecnt)) begin
        pend3.delete(0);
        exp_v3 = 1'b1; exp_d3 = data_in;
      end else begin
        exp_v3 = 1'b0;
`ifdef DMUX_CLEAR_EN
        exp_d3 = 8'd0;
`endif
      end
    end
    if (data_out_valid2 === 1'b1) pulses2++;
    if (data_out_valid3 === 1'b1) pulses3++;
    chk("s2_data",  {24'd0, data_out2},       {24'd0, exp_d2});
    chk("s2_valid", {31'd0, data_out_valid2}, {31'd0, exp_v2});
    chk("s3_data",  {24'd0, data_out3},       {24'd0, exp_d3});
    chk("s3_valid", {31'd0, data_out_valid3}, {31'd0, exp_v3});
  endtask

  initial begin
    int p2, p3;
    // reset held with valid high: outputs cleared, capture after release
    rst = 1'b1; data_in = 8'h5A; data_in_valid = 1'b1;
    tick();
    tick();
    chk("rst_dout", {24'd0, data_out2}, 32'h0);
    chk("rst_vld",  {31'd0, data_out_valid2}, 32'h0);
    rst = 1'b0;
    tick();                                  // edge k
    tick();                                  // k+1
    chk("rel_k1_vld", {31'd0, data_out_valid2}, 32'h0);
    tick();                                  // k+2
    chk("rel_k2_dout", {24'd0, data_out2}, 32'h5A);
    chk("rel_k2_vld",  {31'd0, data_out_valid2}, 32'h1);
    data_in_valid = 1'b0;
    tick();                                  // k+3
    chk("rel_k3_s3dout", {24'd0, data_out3}, 32'h5A);
    chk("rel_k3_s3vld",  {31'd0, data_out_valid3}, 32'h1);
    repeat (4) tick();

    // single transfer of 54
    data_in = 8'd54; data_in_valid = 1'b1;
    tick();                                  // k
    data_in_valid = 1'b0;
    tick();                                  // k+1
    chk("one_k1_vld", {31'd0, data_out_valid2}, 32'h0);
    tick();                                  // k+2
    chk("one_k2_dout", {24'd0, data_out2}, 32'd54);
    chk("one_k2_vld",  {31'd0, data_out_valid2}, 32'h1);
    chk("one_k2_s3vld", {31'd0, data_out_valid3}, 32'h0);
    tick();                                  // k+3
    chk("one_k3_vld",   {31'd0, data_out_valid2}, 32'h0);
    chk("one_k3_s3dout", {24'd0, data_out3}, 32'd54);
    chk("one_k3_s3vld", {31'd0, data_out_valid3}, 32'h1);
`ifdef DMUX_CLEAR_EN
    chk("one_k3_clear", {24'd0, data_out2}, 32'd0);
`else
    chk("one_k3_hold",  {24'd0, data_out2}, 32'd54);
`endif
    repeat (8) tick();
`ifndef DMUX_CLEAR_EN
    chk("one_late_hold", {24'd0, data_out2}, 32'd54);
`endif

    // second transfer of 45
    p2 = pulses2;
    data_in = 8'd45; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (6) tick();
    chk("two_pulses", pulses2 - p2, 32'd1);

    // level valid held 8 cycles: one pulse only
    p2 = pulses2; p3 = pulses3;
    data_in = 8'h33; data_in_valid = 1'b1;
    repeat (8) tick();
`ifndef DMUX_CLEAR_EN
    chk("lvl_dout", {24'd0, data_out2}, 32'h33);
`endif
    data_in_valid = 1'b0;
    repeat (5) tick();
    chk("lvl_pulses2", pulses2 - p2, 32'd1);
    chk("lvl_pulses3", pulses3 - p3, 32'd1);

    // back-to-back pulses with one low cycle between
    p2 = pulses2; p3 = pulses3;
    data_in = 8'hA1; data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    tick();
    data_in_valid = 1'b1;
    tick();
    data_in_valid = 1'b0;
    repeat (6) tick();
    chk("b2b_pulses2", pulses2 - p2, 32'd2);
    chk("b2b_pulses3", pulses3 - p3, 32'd2);

    // reset mid-flight discards the transfer
    p2 = pulses2; p3 = pulses3;
    data_in = 8'hC3; data_in_valid = 1'b1;
    tick();                                  // k
    data_in_valid = 1'b0; rst = 1'b1;
    tick();                                  // k+1 under reset
    rst = 1'b0;
    repeat (6) tick();
    chk("mid_pulses2", pulses2 - p2, 32'd0);
    chk("mid_pulses3", pulses3 - p3, 32'd0);
    chk("mid_dout2", {24'd0, data_out2}, 32'h0);
    chk("mid_dout3", {24'd0, data_out3}, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
